// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings and the default exception vector.
package cpu_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'b000,
        PC_BR   = 3'b001,
        PC_JR   = 3'b010,
        PC_J    = 3'b011,
        PC_CALL = 3'b100,
        PC_RET  = 3'b101,
        PC_ERET = 3'b110,
        PC_RSVD = 3'b111
    } pc_src_e;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full silently overwrites the oldest
// entry, and a pop while empty leaves the stack alone; both raise a one-cycle pulse.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;

    // ptr always indexes the most recent entry; wrapping it makes the overwrite-oldest
    // behaviour fall out of the circular addressing for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (push) begin
                ptr <= ptr + PTR_ONE;
                if (cnt == FULL) ovf <= 1'b1;
                else             cnt <= cnt + CNT_ONE;
            end else if (pop) begin
                if (cnt == '0) begin
                    unf <= 1'b1;
                end else begin
                    ptr <= ptr - PTR_ONE;
                    cnt <= cnt - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[ptr + PTR_ONE] <= din;
    end

    assign top = mem[ptr];

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with branch/jump/call/return selection, exception entry/return
// through an EPC register, and registered status pulses.
module pc_seq_unit
    import cpu_pkg::*;
#(
    parameter int          W         = 32,
    parameter int          ADDR_BITS = 26,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [W-1:0]                  init,
    input  logic                          pc_we,
    input  logic [2:0]                    pc_src,
    input  logic [W-1:0]                  ext,
    input  logic [W-1:0]                  rs,
    input  logic [31:0]                   op,
    input  logic                          exc_req,
    output logic [W-1:0]                  pc0,
    output logic [W-1:0]                  pc4,
    output logic [W-1:0]                  epc,
    output logic [$clog2(RAS_DEPTH):0]    ras_cnt,
    output logic                          ras_ovf,
    output logic                          ras_unf,
    output logic                          misalign,
    output logic                          illegal
);

    localparam logic [W-1:0] EXC_ADDR = W'(EXC_VEC);
    localparam logic [W-1:0] LOW_MASK = W'((64'd1 << (ADDR_BITS + 2)) - 64'd1);
    localparam logic [W-1:0] FOUR     = W'(4);

    logic [W-1:0] pc;
    logic [W-1:0] pc_nxt;
    logic [W-1:0] epc_nxt;
    logic [W-1:0] jmp_tgt;
    logic [W-1:0] rs_tgt;
    logic [W-1:0] ras_top;
    logic         push;
    logic         pop;
    logic         mis_nxt;
    logic         ill_nxt;

    assign pc0     = pc;
    assign pc4     = pc + FOUR;
    assign jmp_tgt = (pc & ~LOW_MASK) | W'({op[ADDR_BITS-1:0], 2'b00});
    assign rs_tgt  = {rs[W-1:2], 2'b00};

    // Exception entry outranks any instruction-driven PC update, including RAS traffic.
    always_comb begin
        pc_nxt  = pc;
        epc_nxt = epc;
        push    = 1'b0;
        pop     = 1'b0;
        mis_nxt = 1'b0;
        ill_nxt = 1'b0;
        if (exc_req) begin
            epc_nxt = pc;
            pc_nxt  = EXC_ADDR;
        end else if (pc_we) begin
            case (pc_src_e'(pc_src))
                PC_SEQ:  pc_nxt = pc + FOUR;
                PC_BR:   pc_nxt = pc + (ext << 2);
                PC_JR: begin
                    pc_nxt  = rs_tgt;
                    mis_nxt = (rs[1:0] != 2'b00);
                end
                PC_J:    pc_nxt = jmp_tgt;
                PC_CALL: begin
                    pc_nxt = jmp_tgt;
                    push   = 1'b1;
                end
                PC_RET: begin
                    pop    = 1'b1;
                    pc_nxt = (ras_cnt != '0) ? ras_top : rs_tgt;
                end
                PC_ERET: pc_nxt = epc;
                default: ill_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= init;
            epc      <= '0;
            misalign <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            epc      <= epc_nxt;
            misalign <= mis_nxt;
            illegal  <= ill_nxt;
        end
    end

    ras_stack #(
        .W     (W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc4),
        .top   (ras_top),
        .cnt   (ras_cnt),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised next-generation program counter for the multicycle CPU.
- Adds to the basic sequential/branch/jr/jump PC:
  - configurable width;
  - a return-address stack (RAS) for call/return;
  - exception entry with an EPC register, and exception return;
  - misalignment and RAS overflow/underflow status.
- Sits between the control unit (pc_we, pc_src, exc_req) and instruction memory (pc0). pc4 feeds the register-file link path.

Parameters:
- W, 32, datapath/PC width in bits.
- ADDR_BITS, 26, width of the absolute jump field taken from op; requires W >= ADDR_BITS+2.
- RAS_DEPTH, 4, return-address stack entries; power of two, 2..16.
- EXC_VEC, 32'h0000_0080, exception entry address (low W bits used).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- init  in  W  PC load value, sampled on every reset cycle.
- pc_we  in  1  PC write enable (one pulse per instruction).
- pc_src  in  3  next-PC select (see Behaviour).
- ext  in  W  sign-extended branch offset, in words.
- rs  in  W  register jump target.
- op  in  32  instruction word; jump field is op[ADDR_BITS-1:0].
- exc_req  in  1  exception request.
- pc0  out  W  current PC.
- pc4  out  W  pc0+4, combinational, mod 2^W.
- epc  out  W  saved exception PC.
- ras_cnt  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  one-cycle pulse: push while full.
- ras_unf  out  1  one-cycle pulse: pop while empty.
- misalign  out  1  one-cycle pulse: rs[1:0] != 0 on a jr.
- illegal  out  1  one-cycle pulse: reserved pc_src.

Behaviour:
- Reset:
  - pc <= init; epc <= 0.
  - RAS emptied (ras_cnt 0, pointer 0).
  - All pulse outputs 0.
  - Reset overrides exc_req and pc_we. A reset mid-call-sequence discards RAS contents.
- Priority: reset > exc_req > pc_we. With none active, all state holds and pulses are 0.
- exc_req=1:
  - epc <= pc; pc <= EXC_VEC.
  - RAS untouched; pc_src and pc_we are ignored.
- pc_we=1, by pc_src:
  - 000 seq: pc <= pc+4.
  - 001 branch: pc <= pc + (ext<<2), two's complement, wraps mod 2^W.
  - 010 jr: pc <= {rs[W-1:2],2'b00}. If rs[1:0] != 0, pulse misalign.
  - 011 jump: pc <= {pc[W-1:ADDR_BITS+2], op[ADDR_BITS-1:0], 2'b00}.
  - 100 call: same target as jump, and push pc+4 onto the RAS.
  - 101 ret:
    - If ras_cnt > 0: pc <= top entry; pop.
    - If empty: pc <= {rs[W-1:2],2'b00} (jr fallback); pulse ras_unf; ras_cnt stays 0.
  - 110 eret: pc <= epc.
  - 111 reserved: pc holds; pulse illegal.
- RAS structure:
  - Circular buffer with top pointer.
  - Push: increments the pointer and writes the entry; ras_cnt saturates at RAS_DEPTH.
  - Push when full: overwrites the oldest entry (ras_cnt stays RAS_DEPTH); pulse ras_ovf.
  - Pop: decrements the pointer and ras_cnt.
- Latency: every update takes effect one cycle after the sampling edge. pc0, pc4, epc and ras_cnt are registered or derived from registered state. Pulses are registered, high exactly the cycle after the causing edge.
- pc4 uses the current pc, not the next one.

Decomposition:
- Shared package cpu_pkg:
  - pc_src encodings: PC_SEQ, PC_BR, PC_JR, PC_J, PC_CALL, PC_RET, PC_ERET, PC_RSVD.
  - Default EXC_VEC constant.
- One sub-module, ras_stack: circular RAS with push/pop/top/cnt/ovf/unf, parametrised by W and RAS_DEPTH.
- pc_seq_unit holds the pc/epc registers and the next-PC mux.

Test Plan:
- Reset with init=32'h0000_3000, then 3 cycles of pc_we=1 with PC_SEQ -> pc0 = 3000, 3004, 3008, 300C; pc4 = pc0+4.
- pc=32'h0000_0010, PC_BR, ext=32'hFFFF_FFFC -> pc0=32'h0000_0000. Then ext=-1 at pc=0 -> pc0=32'hFFFF_FFFC (wrap).
- RAS_DEPTH=4, five PC_CALLs from pc = 100, 200, 300, 400, 500 -> ras_ovf pulse on the 5th. Four PC_RETs -> targets 504, 404, 304, 204. A 5th PC_RET with rs=32'h0000_0777 -> pc0=32'h0000_0774, ras_unf pulse, misalign=0.
- PC_JR with rs=32'h0000_1006 -> pc0=32'h0000_1004, misalign pulses for one cycle.
- exc_req together with pc_we=1/PC_CALL at pc=32'h0000_2000 -> pc0=EXC_VEC, epc=2000, ras_cnt unchanged. Then PC_ERET -> pc0=2000.
- Reset asserted while pc_we=1 and exc_req=1, with ras_cnt=3 -> pc0=init, ras_cnt=0, epc=0, no pulses. PC_RSVD afterwards -> pc holds, illegal pulses.
